// File: rtl/huffman_bit_feeder.sv
// Serializes packed compressed words MSB-first into the Huffman decoder; optional skid word via HUFF_FEEDER_SKID_EN.
// Latency: word accepted at edge t -> first registered out_valid after edge t+1; done one cycle after the last bit.
// Backpressure: in_ready only while fetching (or while the skid word is empty); pause freezes the bitstream in place.
module huffman_bit_feeder #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CNT_W-1:0]  total_bits,
    input  logic [WORD_W-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              pause,
    output logic              out_bit,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WORD_W - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              out_bit_q, out_bit_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic              accept;

`ifdef HUFF_FEEDER_SKID_EN
    logic [WORD_W-1:0] hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;

    assign in_ready = ((state_q == S_FETCH) || (state_q == S_SHIFT)) && !hold_vld_q;
`else
    assign in_ready = (state_q == S_FETCH);
`endif

    assign accept    = in_valid && in_ready;
    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign busy      = (state_q == S_FETCH) || (state_q == S_SHIFT);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        bit_idx_d   = bit_idx_q;
        word_d      = word_q;
        out_bit_d   = 1'b0;
        out_valid_d = 1'b0;
        done_d      = (state_q == S_FINISH);
`ifdef HUFF_FEEDER_SKID_EN
        hold_d      = hold_q;
        hold_vld_d  = hold_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (total_bits != '0) begin
                        state_d     = S_FETCH;
                        remaining_d = total_bits;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FETCH: begin
                if (accept) begin
                    word_d    = in_word;
                    bit_idx_d = IDX_MAX;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
`ifdef HUFF_FEEDER_SKID_EN
                if (accept) begin
                    hold_d     = in_word;
                    hold_vld_d = 1'b1;
                end
`endif
                if (!pause) begin
                    out_valid_d = 1'b1;
                    out_bit_d   = word_q[bit_idx_q];
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        // Last coded bit: pad bits left in the word are dropped.
                        state_d = S_FINISH;
`ifdef HUFF_FEEDER_SKID_EN
                        hold_vld_d = 1'b0;
`endif
                    end else if (bit_idx_q == '0) begin
`ifdef HUFF_FEEDER_SKID_EN
                        if (hold_vld_q) begin
                            word_d     = hold_q;
                            bit_idx_d  = IDX_MAX;
                            hold_vld_d = 1'b0;
                        end else if (accept) begin
                            word_d     = in_word;
                            bit_idx_d  = IDX_MAX;
                            hold_vld_d = 1'b0;
                        end else begin
                            state_d = S_FETCH;
                        end
`else
                        state_d = S_FETCH;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
`ifdef HUFF_FEEDER_SKID_EN
                hold_vld_d = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            bit_idx_q   <= '0;
            word_q      <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef HUFF_FEEDER_SKID_EN
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            bit_idx_q   <= bit_idx_d;
            word_q      <= word_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
`ifdef HUFF_FEEDER_SKID_EN
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
`endif
        end
    end

endmodule

// File: tb/tb_huffman_bit_feeder.sv
// Randomized bench for huffman_bit_feeder: expected bitstream is the word list flattened MSB-first and truncated.
module tb_huffman_bit_feeder;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  total_bits = '0;
    logic [WORD_W-1:0] in_word = '0;
    logic              in_valid = 1'b0;
    logic              pause = 1'b0;
    logic              in_ready, out_bit, out_valid, busy, done;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] words [16];

`ifdef HUFF_FEEDER_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    always #5 clk = ~clk;

    huffman_bit_feeder #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .total_bits(total_bits),
        .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready), .pause(pause),
        .out_bit(out_bit), .out_valid(out_valid), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Caller is positioned 1 time unit after a rising edge.
    task automatic run_stream(input int total, input int nw, input bit rand_valid,
                              input bit rand_pause, input int pause_after,
                              input int pause_len, input int abort_after);
        bit exp_q[$];
        int widx = 0, nbits = 0, cyc = 0, acc0 = -1, first_v = -1, last_v = -1;
        int prev_v = -1, gap = -1, pcnt = 0, done_cyc = -1, need;
        bit hs, aborted = 1'b0;
        need = (total + 31) / 32;
        for (int i = 0; i < total; i++) exp_q.push_back(words[i / 32][31 - (i % 32)]);

        start      = 1'b1;
        total_bits = CNT_W'(total);
        in_valid   = 1'b1;
        in_word    = (nw > 0) ? words[0] : $urandom;
        pause      = 1'b0;
        forever begin
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            cyc++;
            start = 1'b0;
            if (aborted) begin
                check("rst_out_valid", int'(out_valid), 0);
                check("rst_out_bit", int'(out_bit), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_done", int'(done), 0);
                check("rst_in_ready", int'(in_ready), 0);
                reset = 1'b1; in_valid = 1'b0; pause = 1'b0;
                return;
            end
            if (hs) begin
                if (acc0 < 0) acc0 = cyc;
                widx++;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) check("extra_bit", nbits + 1, total);
                else check("bit", int'(out_bit), int'(exp_q.pop_front()));
                if (first_v < 0) first_v = cyc;
                if (nbits == pause_after && prev_v >= 0) gap = cyc - prev_v - 1;
                prev_v = cyc;
                last_v = cyc;
                nbits++;
                if (nbits == pause_after) pcnt = pause_len;
                if (nbits == abort_after) begin
                    reset   = 1'b0;
                    aborted = 1'b1;
                end
            end
            if (done && !aborted) begin
                done_cyc = cyc;
                break;
            end
            if (cyc > 3000) begin
                check("timeout", cyc, 3000);
                break;
            end
            in_valid = rand_valid ? ($urandom % 3 != 0) : 1'b1;
            in_word  = (widx < nw) ? words[widx] : $urandom;
            pause    = rand_pause ? ($urandom % 4 == 0) : (pcnt > 0);
            if (pcnt > 0) pcnt--;
        end

        in_valid = 1'b0;
        pause    = 1'b0;
        @(posedge clk);
        #1;
        check("done_width", int'(done), 0);
        check("idle_busy", int'(busy), 0);
        check("bits_emitted", nbits, total);
        if (total > 0) check("done_after_last", done_cyc - last_v, 1);
        else check("zero_done_latency", int'(done_cyc >= 1 && done_cyc <= 3), 1);
        if (total == 0 || !SKID) check("words_taken", widx, need);
        else check("words_taken", int'(widx >= need && widx <= need + 1), 1);
        if (pause_len > 0) check("pause_gap", gap, pause_len);
        if (!rand_valid && !rand_pause && pause_len == 0 && total > 0) begin
            check("first_latency", first_v - acc0, 1);
            check("stream_span", last_v - acc0, total + (SKID ? 0 : need - 1));
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start = 1'($urandom); total_bits = CNT_W'($urandom);
            in_word = $urandom; in_valid = 1'($urandom); pause = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_bit", int'(out_bit), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_in_ready", int'(in_ready), 0);
        start = 1'b0; in_valid = 1'b0; pause = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", int'(in_ready), 0);
        check("idle_busy0", int'(busy), 0);

        words[0] = 32'hA500_0000;
        run_stream(8, 1, 1'b0, 1'b0, -1, 0, -1);

        words[0] = 32'hFFFF_FFFF;
        words[1] = 32'h8000_0000;
        run_stream(40, 2, 1'b0, 1'b0, -1, 0, -1);

        words[0] = 32'h0F0F_0F0F;
        run_stream(32, 1, 1'b0, 1'b0, 6, 3, -1);

        run_stream(0, 0, 1'b0, 1'b0, -1, 0, -1);

        for (int i = 0; i < 8; i++) words[i] = $urandom;
        run_stream(256, 8, 1'b0, 1'b0, -1, 0, -1);

        for (int i = 0; i < 2; i++) words[i] = $urandom;
        run_stream(64, 2, 1'b0, 1'b0, -1, 0, 10);
        @(posedge clk);
        #1;
        words[0] = 32'h6000_0000;
        run_stream(4, 1, 1'b0, 1'b0, -1, 0, -1);

        for (int t = 0; t < 6; t++) begin
            int total;
            total = $urandom_range(1, 200);
            for (int i = 0; i < 16; i++) words[i] = $urandom;
            run_stream(total, (total + 31) / 32, 1'b1, 1'b1, -1, 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
